// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the AXI-Stream frame scheduler.
package frame_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;
  // Lowest bit of the frame tag field in the first beat of a frame
  localparam int TAG_LSB    = DATA_W_DEF - CNT_W_DEF;

endpackage

// File: rtl/frame_beat_counter.sv
// Beat and inter-frame gap counters for the frame scheduler; clear has priority over increment.
module frame_beat_counter
  import frame_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_beat_clr,
  input  logic             i_beat_inc,
  input  logic             i_gap_clr,
  input  logic             i_gap_inc,
  input  logic [CNT_W-1:0] i_gap_len,
  output logic [CNT_W-1:0] o_beat_cnt,
  output logic             o_gap_last
);

  logic [CNT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0] r_gap_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (i_beat_clr)      r_beat_cnt <= '0;
      else if (i_beat_inc) r_beat_cnt <= r_beat_cnt + CNT_W'(1);

      if (i_gap_clr)       r_gap_cnt  <= '0;
      else if (i_gap_inc)  r_gap_cnt  <= r_gap_cnt + CNT_W'(1);
    end
  end

  assign o_beat_cnt = r_beat_cnt;
  assign o_gap_last = (r_gap_cnt == i_gap_len - CNT_W'(1));

endmodule

// File: rtl/axis_frame_scheduler.sv
// Frames the noise-sample stream into tlast-delimited bursts separated by programmable idle gaps.
// Define FRAME_TAG_EN to stamp the frame number into the top CNT_W bits of each frame's first beat.
module axis_frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  frame_len_cfg,
  input  logic [CNT_W-1:0]  num_frames_cfg,
  input  logic [CNT_W-1:0]  gap_cfg,
  input  logic [DATA_W-1:0] src_tdata,
  input  logic              src_tvalid,
  output logic              src_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frame_cnt
);

  state_t           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_stop_pend;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_beat_cnt;
  logic             w_gap_last;
  logic             w_run;
  logic             w_in_gap;
  logic             w_start_ok;
  logic             w_beat;
  logic             w_tlast;
  logic             w_end_run;

  assign w_run      = (r_state == ST_RUN);
  assign w_in_gap   = (r_state == ST_GAP);
  assign w_start_ok = (r_state == ST_IDLE) && start && (frame_len_cfg != '0);
  assign w_beat     = w_run && src_tvalid && m_axis_tready;
  assign w_tlast    = w_run && (w_beat_cnt == r_len - CNT_W'(1));
  // A stop arriving on the tlast beat itself still ends the run after this frame
  assign w_end_run  = r_stop_pend || stop ||
                      ((r_num != '0) && (r_frame_cnt + CNT_W'(1) == r_num));

  frame_beat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk      (s_axis_aclk),
    .i_rst_n    (s_axis_aresetn),
    .i_beat_clr (w_start_ok || (w_beat && w_tlast)),
    .i_beat_inc (w_beat),
    .i_gap_clr  (!w_in_gap || w_gap_last),
    .i_gap_inc  (w_in_gap),
    .i_gap_len  (r_gap),
    .o_beat_cnt (w_beat_cnt),
    .o_gap_last (w_gap_last)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_num       <= '0;
      r_gap       <= '0;
      r_frame_cnt <= '0;
      r_stop_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_len       <= frame_len_cfg;
            r_num       <= num_frames_cfg;
            r_gap       <= gap_cfg;
            r_frame_cnt <= '0;
            r_stop_pend <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_beat && w_tlast) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            if (w_end_run) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_gap != '0) begin
              r_state <= ST_GAP;
            end
          end else if (stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        ST_GAP: begin
          if (stop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_gap_last) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_stop_pend <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign src_tready    = w_run && m_axis_tready;
  assign m_axis_tvalid = w_run && src_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign frame_cnt     = r_frame_cnt;

`ifdef FRAME_TAG_EN
  always_comb begin
    m_axis_tdata = src_tdata;
    if (w_run && (w_beat_cnt == '0)) m_axis_tdata[DATA_W-1 -: CNT_W] = r_frame_cnt;
  end
`else
  assign m_axis_tdata = src_tdata;
`endif

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Self-checking bench for axis_frame_scheduler: table-driven runs with a beat scoreboard plus reset corner cases.
`timescale 1ns/1ps
module tb_axis_frame_scheduler;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  frame_len_cfg;
  logic [CNT_W-1:0]  num_frames_cfg;
  logic [CNT_W-1:0]  gap_cfg;
  logic [DATA_W-1:0] src_tdata;
  logic              src_tvalid;
  logic              src_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  axis_frame_scheduler #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .start          (start),
    .stop           (stop),
    .frame_len_cfg  (frame_len_cfg),
    .num_frames_cfg (num_frames_cfg),
    .gap_cfg        (gap_cfg),
    .src_tdata      (src_tdata),
    .src_tvalid     (src_tvalid),
    .src_tready     (src_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .busy           (busy),
    .done           (done),
    .frame_cnt      (frame_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    string name;
    int    len;
    int    num;
    int    gap;
    int    rdy_toggle;
    int    stop_at;
    int    exp_beats;
    int    exp_frames;
    int    exp_idle;
  } case_t;

  beat_t exp_q[$];
  case_t cases[5];
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, ".busy"},       64'(busy),          64'd0);
    check({tag, ".done"},       64'(done),          64'd0);
    check({tag, ".src_tready"}, 64'(src_tready),    64'd0);
    check({tag, ".tvalid"},     64'(m_axis_tvalid), 64'd0);
    check({tag, ".tlast"},      64'(m_axis_tlast),  64'd0);
    check({tag, ".frame_cnt"},  64'(frame_cnt),     64'd0);
  endtask

  // Runs one programmed transfer; expected beats go on the scoreboard before start.
  task automatic run_case(input case_t c);
    int    accepted = 0;
    int    idle = 0;
    int    notbusy = 0;
    int    done_cnt = 0;
    int    rdy_err = 0;
    int    last_cyc = -1;
    int    done_cyc = -1;
    int    cyc = 0;
    bit    finished = 0;
    bit    acc;
    beat_t b;

    for (int i = 0; i < c.exp_beats; i++) begin
      b.data = 64'(i + 1);
`ifdef FRAME_TAG_EN
      if (i % c.len == 0) b.data[63:48] = 16'(i / c.len);
`endif
      b.last = ((i + 1) % c.len) == 0;
      exp_q.push_back(b);
    end

    src_tdata      = 64'd1;
    src_tvalid     = 1'b1;
    m_axis_tready  = 1'b1;
    frame_len_cfg  = CNT_W'(c.len);
    num_frames_cfg = CNT_W'(c.num);
    gap_cfg        = CNT_W'(c.gap);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (!finished && cyc < 6000) begin
      @(negedge clk);
      acc = m_axis_tvalid && m_axis_tready;
      if (busy && !m_axis_tvalid) idle++;
      if (m_axis_tvalid && (src_tready !== m_axis_tready)) rdy_err++;
      if (!busy && !done && accepted < c.exp_beats) notbusy++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (acc) begin
        if (exp_q.size() == 0) begin
          check({c.name, ".extra_beat"}, 64'(accepted + 1), 64'(c.exp_beats));
        end else begin
          b = exp_q.pop_front();
          check($sformatf("%s.data[%0d]", c.name, accepted),  m_axis_tdata,      b.data);
          check($sformatf("%s.tlast[%0d]", c.name, accepted), 64'(m_axis_tlast), 64'(b.last));
        end
        accepted++;
        if (accepted == c.exp_beats) last_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) finished = 1;
      @(posedge clk); #1;
      if (acc) src_tdata = src_tdata + 64'd1;
      stop = (c.stop_at != 0) && acc && (accepted == c.stop_at);
      if (c.rdy_toggle != 0) m_axis_tready = ~m_axis_tready;
      cyc++;
    end
    stop = 1'b0;
    m_axis_tready = 1'b1;

    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no done after %0d cycles, beats=%0d expected %0d",
               c.name, cyc, accepted, c.exp_beats);
    end
    check({c.name, ".beats"},      64'(accepted),           64'(c.exp_beats));
    check({c.name, ".frame_cnt"},  64'(frame_cnt),          64'(c.exp_frames));
    check({c.name, ".idle"},       64'(idle),               64'(c.exp_idle));
    check({c.name, ".busy_drop"},  64'(notbusy),            64'd0);
    check({c.name, ".done_width"}, 64'(done_cnt),           64'd1);
    check({c.name, ".done_lat"},   64'(done_cyc - last_cyc), 64'd1);
    check({c.name, ".rdy_mirror"}, 64'(rdy_err),            64'd0);
    check({c.name, ".sb_left"},    64'(exp_q.size()),       64'd0);
    check({c.name, ".busy_end"},   64'(busy),               64'd0);
    exp_q.delete();
  endtask

  initial begin
    case_t c;
    cases[0] = '{"basic",    4,    3, 0, 0, 0,   12,   3, 0};
    cases[1] = '{"gap",      8,    2, 5, 0, 0,   16,   2, 5};
    cases[2] = '{"bpress",   16,   1, 0, 1, 0,   16,   1, 0};
    cases[3] = '{"stop",     1024, 0, 0, 0, 300, 1024, 1, 0};
    cases[4] = '{"len1_gap", 1,    3, 2, 0, 0,   3,    3, 4};

    rst_n          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    frame_len_cfg  = '0;
    num_frames_cfg = '0;
    gap_cfg        = '0;
    src_tdata      = '0;
    src_tvalid     = 1'b1;
    m_axis_tready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_low("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_case(cases[i]);
      repeat (2) @(posedge clk);
      #1;
    end

    // Zero frame length must be ignored
    frame_len_cfg  = '0;
    num_frames_cfg = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("len0.busy",       64'(busy),          64'd0);
    check("len0.tvalid",     64'(m_axis_tvalid), 64'd0);
    check("len0.src_tready", 64'(src_tready),    64'd0);
    @(posedge clk); #1;

    // Reset in the middle of a frame, then a fresh run must start at beat 0
    frame_len_cfg  = 16'd8;
    num_frames_cfg = 16'd1;
    gap_cfg        = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst.busy_before", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    c = '{"after_rst", 4, 1, 0, 0, 0, 4, 1, 0};
    run_case(c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
